// File: rtl/multi_ch_toggle_gen_if.sv
// Control/status bundle for multi_ch_toggle_gen.
// The master side (lab logic or bench) drives enables, modes, sync and the
// terminal-count load bus; the slave side (the generator) returns the
// per-channel registered outputs Q and tick.
interface multi_ch_toggle_gen_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 22
);

  // Width of the load channel index; at least one bit even for CH == 1.
  localparam int LW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]    Enable;
  logic [CH-1:0]    mode;
  logic             sync;
  logic             load;
  logic [LW-1:0]    load_ch;
  logic [CNT_W-1:0] load_val;
  logic [CH-1:0]    Q;
  logic [CH-1:0]    tick;

  modport master (
    output Enable,
    output mode,
    output sync,
    output load,
    output load_ch,
    output load_val,
    input  Q,
    input  tick
  );

  modport slave (
    input  Enable,
    input  mode,
    input  sync,
    input  load,
    input  load_ch,
    input  load_val,
    output Q,
    output tick
  );

endinterface

// File: rtl/multi_ch_toggle_gen.sv
// Multi-channel enable-gated toggle/pulse divider.
// Each channel counts enabled cycles up to its own run-time loadable terminal
// count. On the terminal cycle the channel emits a one-cycle tick and either
// toggles Q (square wave) or raises Q for one cycle (pulse). A global sync
// restarts every channel phase-aligned; a load updates one channel's limit
// and clears its count so the counter can never run past the limit.
module multi_ch_toggle_gen #(
  parameter int CH          = 4,
  parameter int CNT_W       = 22,
  parameter int DEFAULT_DIV = 2499999
) (
  input  logic                  clk_in1,
  input  logic                  clr,
  multi_ch_toggle_gen_if.slave  bus
);

  localparam int LW = (CH > 1) ? $clog2(CH) : 1;

  // Terminal count every channel starts from after reset.
  localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  // Registered per-channel state.
  logic [CH-1:0][CNT_W-1:0] r_cnt;
  logic [CH-1:0][CNT_W-1:0] r_lim;
  logic [CH-1:0]            r_q;
  logic [CH-1:0]            r_tick;

  // Next-state values computed combinationally.
  logic [CH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [CH-1:0][CNT_W-1:0] w_lim_nxt;
  logic [CH-1:0]            w_q_nxt;
  logic [CH-1:0]            w_tick_nxt;
  logic [CH-1:0]            w_ld_hit;
  logic [CH-1:0]            w_term;

  // Decode which channel (if any) the load bus addresses; an index >= CH
  // matches no channel, so out-of-range loads are silently ignored.
  always_comb begin
    w_ld_hit = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.load && (bus.load_ch == LW'(i))) begin
        w_ld_hit[i] = 1'b1;
      end else begin
        w_ld_hit[i] = 1'b0;
      end
    end
  end

  // Terminal detection: the counter has reached this channel's limit.
  always_comb begin
    w_term = '0;
    for (int i = 0; i < CH; i++) begin
      if (r_cnt[i] == r_lim[i]) begin
        w_term[i] = 1'b1;
      end else begin
        w_term[i] = 1'b0;
      end
    end
  end

  // Limit register update: a load always writes its addressed channel, even
  // when a sync on the same edge overrides everything else.
  always_comb begin
    w_lim_nxt = r_lim;
    for (int i = 0; i < CH; i++) begin
      if (w_ld_hit[i]) begin
        w_lim_nxt[i] = bus.load_val;
      end else begin
        w_lim_nxt[i] = r_lim[i];
      end
    end
  end

  // Per-channel count/output priority: sync, load, disable, terminal, count.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_q_nxt    = r_q;
    w_tick_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.sync) begin
        // Phase-aligned restart of every channel.
        w_cnt_nxt[i]  = CNT_ZERO;
        w_q_nxt[i]    = 1'b0;
        w_tick_nxt[i] = 1'b0;
      end else if (w_ld_hit[i]) begin
        // New limit takes effect from a fresh count; Q keeps its level.
        w_cnt_nxt[i]  = CNT_ZERO;
        w_q_nxt[i]    = r_q[i];
        w_tick_nxt[i] = 1'b0;
      end else if (!bus.Enable[i]) begin
        // Frozen: count and level hold, no strobe.
        w_cnt_nxt[i]  = r_cnt[i];
        w_q_nxt[i]    = r_q[i];
        w_tick_nxt[i] = 1'b0;
      end else if (w_term[i]) begin
        w_cnt_nxt[i]  = CNT_ZERO;
        w_tick_nxt[i] = 1'b1;
        if (bus.mode[i]) begin
          w_q_nxt[i] = 1'b1;
        end else begin
          w_q_nxt[i] = ~r_q[i];
        end
      end else begin
        w_cnt_nxt[i]  = r_cnt[i] + CNT_ONE;
        w_tick_nxt[i] = 1'b0;
        if (bus.mode[i]) begin
          w_q_nxt[i] = 1'b0;
        end else begin
          w_q_nxt[i] = r_q[i];
        end
      end
    end
  end

  // State registers with asynchronous clear back to the default divider.
  always_ff @(posedge clk_in1 or negedge clr) begin
    if (!clr) begin
      r_cnt  <= '0;
      r_lim  <= {CH{DEF_LIM}};
      r_q    <= '0;
      r_tick <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_lim  <= w_lim_nxt;
      r_q    <= w_q_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  // Outputs come straight from flops so downstream logic sees no glitches.
  assign bus.Q    = r_q;
  assign bus.tick = r_tick;

endmodule

// File: tb/tb_multi_ch_toggle_gen.sv
// Directed bench for multi_ch_toggle_gen: a CH=4 build exercises the main
// behaviour and a CH=3 build exercises out-of-range load indices.
module tb_multi_ch_toggle_gen;

  logic clk;
  logic clr;

  int n_tests = 0;
  int n_fail  = 0;

  multi_ch_toggle_gen_if #(.CH(4), .CNT_W(8)) bus4 ();
  multi_ch_toggle_gen_if #(.CH(3), .CNT_W(8)) bus3 ();

  multi_ch_toggle_gen #(.CH(4), .CNT_W(8), .DEFAULT_DIV(3)) u_dut4 (
    .clk_in1 (clk),
    .clr     (clr),
    .bus     (bus4.slave)
  );

  multi_ch_toggle_gen #(.CH(3), .CNT_W(8), .DEFAULT_DIV(3)) u_dut3 (
    .clk_in1 (clk),
    .clr     (clr),
    .bus     (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0;
    bus4.Enable = '0; bus4.mode = '0; bus4.sync = 1'b0; bus4.load = 1'b0;
    bus4.load_ch = '0; bus4.load_val = '0;
    bus3.Enable = '0; bus3.mode = '0; bus3.sync = 1'b0; bus3.load = 1'b0;
    bus3.load_ch = '0; bus3.load_val = '0;

    // Reset state.
    repeat (2) step();
    chk("rst_q4", bus4.Q, 32'd0);
    chk("rst_tick4", bus4.tick, 32'd0);
    chk("rst_q3", bus3.Q, 32'd0);
    chk("rst_tick3", bus3.tick, 32'd0);

    // 1: channel 0 toggle mode with default limit 3.
    clr = 1'b1;
    bus4.Enable = 4'b0001;
    for (int e = 1; e <= 16; e++) begin
      step();
      chk("t1_tick", bus4.tick, (e % 4 == 0) ? 32'h1 : 32'h0);
      chk("t1_q", bus4.Q, (((e / 4) % 2) == 1) ? 32'h1 : 32'h0);
    end

    // 2: load channel 1 with limit 0 in pulse mode.
    bus4.load = 1'b1; bus4.load_ch = 2'd1; bus4.load_val = 8'd0;
    bus4.mode = 4'b0010; bus4.Enable = 4'b0011;
    step();
    bus4.load = 1'b0;
    chk("t2_q1_load", bus4.Q[1], 32'd0);
    chk("t2_tick1_load", bus4.tick[1], 32'd0);
    for (int k = 2; k <= 6; k++) begin
      step();
      chk("t2_q1", bus4.Q[1], 32'd1);
      chk("t2_tick1", bus4.tick[1], 32'd1);
      chk("t2_tick0", bus4.tick[0], (k == 4) ? 32'd1 : 32'd0);
    end

    // 3: freeze channel 0 at cnt=2 with Q=1.
    bus4.Enable = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_tick0_frozen", bus4.tick[0], 32'd0);
      chk("t3_q0_frozen", bus4.Q[0], 32'd1);
    end
    bus4.Enable = 4'b0011;
    step();
    chk("t3_tick0_e1", bus4.tick[0], 32'd0);
    step();
    chk("t3_tick0_e2", bus4.tick[0], 32'd1);
    chk("t3_q0_e2", bus4.Q[0], 32'd0);

    // 4: offset channels 0 and 2, both Q=1, then sync.
    bus4.Enable = 4'b0110;
    repeat (2) step();
    bus4.Enable = 4'b0111;
    repeat (4) step();
    chk("t4_q0_pre", bus4.Q[0], 32'd1);
    chk("t4_q2_pre", bus4.Q[2], 32'd1);
    bus4.sync = 1'b1;
    step();
    bus4.sync = 1'b0;
    chk("t4_q_sync", bus4.Q, 32'd0);
    chk("t4_tick_sync", bus4.tick, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t4_tick0", bus4.tick[0], (k == 4) ? 32'd1 : 32'd0);
      chk("t4_tick2", bus4.tick[2], (k == 4) ? 32'd1 : 32'd0);
    end

    // 5: load channel 3 with limit 7; channel 0 must keep its period.
    bus4.load = 1'b1; bus4.load_ch = 2'd3; bus4.load_val = 8'd7;
    bus4.Enable = 4'b1111;
    step();
    bus4.load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t5_tick3", bus4.tick[3], (k % 8 == 0) ? 32'd1 : 32'd0);
      chk("t5_q3", bus4.Q[3], (k >= 8 && k < 16) ? 32'd1 : 32'd0);
      chk("t5_tick0", bus4.tick[0], ((k + 1) % 4 == 0) ? 32'd1 : 32'd0);
    end

    // 5b: CH=3 build, load index 3 is out of range and must change nothing.
    bus3.Enable = 3'b111;
    bus3.load = 1'b1; bus3.load_ch = 2'd3; bus3.load_val = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t5b_tick", bus3.tick, (k % 4 == 0) ? 32'h7 : 32'h0);
    end
    bus3.load = 1'b0;

    // 6: asynchronous clear between edges while channel 1 has Q=1, tick=1.
    @(posedge clk);
    #3;
    chk("t6_q1_before", bus4.Q[1], 32'd1);
    clr = 1'b0;
    #1;
    chk("t6_q_async", bus4.Q, 32'd0);
    chk("t6_tick_async", bus4.tick, 32'd0);
    chk("t6_q3_async", bus3.Q, 32'd0);
    step();
    clr = 1'b1;
    bus4.mode = 4'b0000;
    bus4.Enable = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t6_tick_rel", bus4.tick, (k == 4) ? 32'hF : 32'h0);
    end
    chk("t6_q_rel", bus4.Q, 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ch_toggle_gen.md
Name: multi_ch_toggle_gen

Overview:
- Parametrised, multi-channel successor to the single-channel enable-gated toggle divider.
- Each of CH channels has its own run-time loadable terminal count.
- Each channel has a selectable output mode: square-wave toggle or one-cycle pulse.
- A global sync restarts all channels phase-aligned. The block sits after the clocking wizard output and drives LEDs or timing strobes for downstream lab logic.

Parameters:
- CH, 4, number of independent channels.
- CNT_W, 22, counter and terminal-count width in bits.
- DEFAULT_DIV, 2499999, terminal count loaded into every channel at reset. Must fit in CNT_W bits.

Ports:
- clk_in1  input  1  system clock (divided clock from clocking wizard); all state on posedge.
- clr  input  1  asynchronous, active-low reset.
- Enable  input  CH  per-channel count enable, level.
- mode  input  CH  per-channel output mode: 0 = toggle, 1 = pulse.
- sync  input  1  synchronous global restart, one-cycle pulse or level.
- load  input  1  write strobe for terminal count.
- load_ch  input  clog2(CH) (min 1)  channel index for load.
- load_val  input  CNT_W  new terminal count.
- Q  output  CH  per-channel registered output.
- tick  output  CH  per-channel registered one-cycle terminal strobe.

Behaviour:
- Reset (clr=0, asynchronous):
  - cnt[i]=0, lim[i]=DEFAULT_DIV, Q=0, tick=0.
  - Release is synchronous to the next posedge; no count is lost or added on the release edge.
- Per channel i, each posedge, applied in priority order:
  1. sync=1:
     - cnt[i]<=0, Q[i]<=0, tick[i]<=0 for all channels.
     - If load is also 1, lim[load_ch] is still written, but its cnt is 0 regardless.
  2. load=1 and load_ch==i:
     - lim[i]<=load_val, cnt[i]<=0, tick[i]<=0.
     - Q[i] holds.
     - load_ch>=CH: no channel is written, and all channels continue normally.
  3. Enable[i]=0:
     - cnt[i] and Q[i] hold; tick[i]<=0.
  4. Enable[i]=1 and cnt[i]==lim[i] (terminal):
     - cnt[i]<=0, tick[i]<=1.
     - Q[i]<=~Q[i] if mode[i]=0; Q[i]<=1 if mode[i]=1.
  5. Enable[i]=1, not terminal:
     - cnt[i]<=cnt[i]+1, tick[i]<=0.
     - Q[i] holds if mode[i]=0; Q[i]<=0 if mode[i]=1.
- Timing:
  - Terminal occurs every lim+1 enabled cycles.
  - Toggle-mode Q period = 2*(lim+1) enabled cycles, 50% duty.
  - Latency: tick/Q update on the same edge on which cnt==lim is sampled; outputs are visible after that edge.
- lim=0:
  - Every enabled cycle is terminal.
  - tick stays high continuously.
  - Toggle Q toggles every cycle; pulse Q stays 1.
- cnt never exceeds lim, because every load clears cnt. The counter never wraps through 2^CNT_W.
- Mode change mid-count:
  - Takes effect on the same edge.
  - pulse→toggle: Q holds its current value, then toggles at the next terminal.
  - toggle→pulse: Q goes 0 on the next non-terminal enabled cycle.
- Channels are fully independent, except for sync and the shared load bus.

Test Plan (CH=4, CNT_W=8, DEFAULT_DIV=3):
1. Reset, then release clr. Enable=4'b0001, mode=0, hold 16 cycles.
   - Required: tick[0]=1 after edges 4, 8, 12, 16 only.
   - Required: Q[0] rises after edge 4, falls after edge 8.
   - Required: Q[3:1] and tick[3:1] stay 0.
2. load=1, load_ch=1, load_val=0, mode[1]=1, Enable[1]=1.
   - Required: Q[1]=1 and tick[1]=1 from the second edge after load onward.
   - Required: the lim read back through the tick period equals 1 cycle.
3. Channel 0 running. Drop Enable[0] for 5 cycles when cnt=2, then re-raise.
   - Required: tick[0]=0 and Q[0] frozen while disabled.
   - Required: the next tick arrives exactly 2 enabled edges after re-raise.
4. Channels 0 and 2 at differing counts with Q=1. Pulse sync once.
   - Required: all Q=0 and tick=0 after that edge.
   - Required: ticks on channels 0 and 2 coincide 4 edges later.
5. load with load_ch=3 (valid) and load_val=7.
   - Required: tick[3] period is 8 cycles.
   - Then load_ch beyond CH (use CH=3 build): no lim changes, and periods are unchanged.
6. Assert clr=0 mid-count, asynchronously between edges.
   - Required: Q, tick, and cnt clear immediately; lim returns to 3.
   - Required: the first tick is 4 edges after release.
